// File: rtl/spi_responder_pkg.sv
// Shared definitions for the SPI responder: bus mode, default idle byte,
// the host timing limit the bench paces itself by, and the FSM state type.
package spi_responder_pkg;

    // Mode 0: SCLK idles low, data sampled on rising, changed on falling
    localparam int SPI_MODE = 0;

    // Byte shifted out whenever nothing has been queued for transmission
    localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'hFF;

    // Shortest SCLK half-period (and CS_N-to-first-edge time) in clk25 cycles
    localparam int MIN_HALF_PERIOD = 4;

    typedef enum logic {
        ST_IDLE,
        ST_SELECTED
    } spi_state_t;

    // True when the rising edge about to be counted completes a byte
    function automatic logic is_last_bit(input logic [2:0] cnt);
        return (cnt == 3'd7);
    endfunction

endpackage

// File: rtl/spi_responder_sync_ff.sv
// Multi-flop synchronizer for one asynchronous input bit, with a
// configurable reset value so idle-high lines come out of reset idle.
module sync_ff
    import spi_responder_pkg::*;
#(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk25,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the flop chain; the last stage is safe to use
    always_ff @(posedge clk25) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversamples the host's SCLK/CS_N/MOSI with clk25,
// frames received bytes MSB-first and shifts queued bytes back on MISO.
module spi_responder
    import spi_responder_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = DEFAULT_IDLE_BYTE
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       frame_end,
    output logic       underrun
);

    // SCLK idle level follows the bus mode (low for modes 0 and 1)
    localparam logic SCLK_IDLE = (SPI_MODE >= 2);

    logic sclk_s;
    logic cs_n_s;
    logic mosi_s;
    logic sclk_d;
    logic cs_n_d;

    logic [SYNC_STAGES:0] settle_sr;
    logic                 settled;

    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    spi_state_t state;
    spi_state_t state_next;

    logic       armed;
    logic       first_flag;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] hold_data;
    logic       hold_full;

    logic start_frame;
    logic end_frame;
    logic sample_bit;
    logic shift_out;
    logic load_req;
    logic accept;

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(SCLK_IDLE)) u_sync_sclk (
        .clk25 (clk25),
        .rst   (rst),
        .d     (spi_sclk),
        .q     (sclk_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
        .clk25 (clk25),
        .rst   (rst),
        .d     (spi_cs_n),
        .q     (cs_n_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk25 (clk25),
        .rst   (rst),
        .d     (spi_mosi),
        .q     (mosi_s)
    );

    // Delayed copies for edge detection, plus a settle pipeline that hides
    // the synchronizers' reset values until real input has flushed through
    always_ff @(posedge clk25) begin
        if (rst) begin
            sclk_d    <= SCLK_IDLE;
            cs_n_d    <= 1'b1;
            settle_sr <= '0;
        end else begin
            sclk_d    <= sclk_s;
            cs_n_d    <= cs_n_s;
            settle_sr <= {settle_sr[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign settled   = settle_sr[SYNC_STAGES];
    assign sclk_rise = settled &  sclk_s & ~sclk_d;
    assign sclk_fall = settled & ~sclk_s &  sclk_d;
    assign cs_rise   = settled &  cs_n_s & ~cs_n_d;
    assign cs_fall   = settled & ~cs_n_s &  cs_n_d;

    // Only a CS_N fall that follows a seen-high CS_N starts a frame, so a
    // transfer already running when reset releases is skipped
    always_ff @(posedge clk25) begin
        if (rst) begin
            armed <= 1'b0;
        end else if (settled && cs_n_s) begin
            armed <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk25) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and datapath strobes; a CS_N edge masks any SCLK edge
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        sample_bit  = 1'b0;
        shift_out   = 1'b0;
        load_req    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs_fall && armed) begin
                    state_next  = ST_SELECTED;
                    start_frame = 1'b1;
                    load_req    = 1'b1;
                end
            end
            ST_SELECTED: begin
                if (cs_rise) begin
                    state_next = ST_IDLE;
                    end_frame  = 1'b1;
                end else if (sclk_rise) begin
                    sample_bit = 1'b1;
                end else if (sclk_fall) begin
                    if (bit_cnt == 3'd0) begin
                        load_req = 1'b1;
                    end else begin
                        shift_out = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // A byte is taken only while the holding register is empty at the start
    // of the cycle, so a same-cycle load never sees it
    assign accept = tx_valid & ~hold_full;

    // Transmit side: holding register handshake and the MISO shift register
    always_ff @(posedge clk25) begin
        if (rst) begin
            hold_data <= '0;
            hold_full <= 1'b0;
            tx_shift  <= IDLE_BYTE;
            underrun  <= 1'b0;
        end else begin
            underrun <= load_req & ~hold_full;
            if (accept) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end else if (load_req) begin
                hold_full <= 1'b0;
            end
            if (load_req) begin
                tx_shift <= hold_full ? hold_data : IDLE_BYTE;
            end else if (shift_out) begin
                tx_shift <= {tx_shift[6:0], 1'b1};
            end
        end
    end

    // Receive side: bit counter, MOSI shift register and byte strobes
    always_ff @(posedge clk25) begin
        if (rst) begin
            bit_cnt    <= '0;
            first_flag <= 1'b0;
            rx_shift   <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_first   <= 1'b0;
            frame_end  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            rx_first  <= 1'b0;
            frame_end <= end_frame;
            if (start_frame || end_frame) begin
                bit_cnt <= '0;
            end
            if (start_frame) begin
                first_flag <= 1'b1;
            end
            if (sample_bit) begin
                rx_shift <= {rx_shift[6:0], mosi_s};
                bit_cnt  <= bit_cnt + 3'd1;
                if (is_last_bit(bit_cnt)) begin
                    rx_data    <= {rx_shift[6:0], mosi_s};
                    rx_valid   <= 1'b1;
                    rx_first   <= first_flag;
                    first_flag <= 1'b0;
                end
            end
        end
    end

    assign spi_miso_oe = (state == ST_SELECTED);
    assign spi_miso    = (state == ST_SELECTED) ? tx_shift[7] : 1'b1;
    assign tx_ready    = ~hold_full;

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: a behavioural SPI host drives frames, a queue
// model predicts received bytes, MISO bytes and pulse counts, and separate
// monitors compare the DUT's outputs against those predictions.
module tb_spi_responder;
    import spi_responder_pkg::*;

    typedef logic [7:0] byte_arr_t [16];
    typedef bit         en_arr_t   [16];

    logic       clk25 = 1'b0;
    logic       rst;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       frame_end;
    logic       underrun;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] model_hold [$];
    logic [8:0] exp_rx     [$];
    logic [7:0] exp_miso   [$];
    int  exp_underrun   = 0;
    int  exp_frame_end  = 0;
    int  seen_underrun  = 0;
    int  seen_frame_end = 0;
    bit  miso_track     = 1'b1;

    always #20 clk25 = ~clk25;

    spi_responder #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
        .clk25       (clk25),
        .rst         (rst),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_first    (rx_first),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .frame_end   (frame_end),
        .underrun    (underrun)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic report_fail(input string name, input logic [31:0] actual);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: got 0x%0h with nothing expected", name, actual);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk25);
        #1;
    endtask

    // Host's view of the holding register: a queued byte if any, else the idle byte
    function automatic logic [7:0] model_load();
        if (model_hold.size() != 0) begin
            return model_hold.pop_front();
        end
        exp_underrun++;
        return 8'hFF;
    endfunction

    task automatic offer_tx(input logic [7:0] b);
        check_output("tx_ready_before_offer", 32'(tx_ready), 32'(model_hold.size() == 0));
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk25);
        #1;
        tx_valid = 1'b0;
        if (model_hold.size() == 0) begin
            model_hold.push_back(b);
        end
    endtask

    task automatic clock_bit(input logic v, input int hp);
        spi_mosi = v;
        wait_cycles(hp);
        spi_sclk = 1'b1;
        wait_cycles(hp);
        spi_sclk = 1'b0;
    endtask

    // One honoured frame of nbits; the last SCLK fall and the CS_N rise coincide
    task automatic apply_stimulus(input int nbits, input byte_arr_t mosi_b,
                                  input byte_arr_t feed_b, input en_arr_t feed_en, input int hp);
        logic [7:0] cur_tx;
        bit first_byte;
        int i;
        int k;
        first_byte = 1'b1;
        spi_cs_n   = 1'b0;
        cur_tx     = model_load();
        spi_mosi   = mosi_b[0][7];
        wait_cycles(hp);
        for (int b = 0; b < nbits; b++) begin
            i = b / 8;
            k = b % 8;
            if (k == 7) begin
                exp_rx.push_back({first_byte, mosi_b[i]});
                first_byte = 1'b0;
                if (miso_track) exp_miso.push_back(cur_tx);
            end
            spi_sclk = 1'b1;
            wait_cycles(hp);
            if (b == nbits - 1) begin
                spi_sclk = 1'b0;
                spi_cs_n = 1'b1;
            end else begin
                spi_sclk = 1'b0;
                spi_mosi = mosi_b[(b + 1) / 8][7 - ((b + 1) % 8)];
                if (k == 7) cur_tx = model_load();
                if (k == 2 && i + 1 < 16 && feed_en[i + 1]) begin
                    offer_tx(feed_b[i + 1]);
                    wait_cycles(hp - 1);
                end else begin
                    wait_cycles(hp);
                end
            end
        end
        exp_frame_end++;
        spi_mosi = 1'b0;
        wait_cycles(2 * hp);
    endtask

    task automatic end_test(input string name);
        wait_cycles(6);
        check_output({name, "_underrun_count"}, 32'(seen_underrun), 32'(exp_underrun));
        check_output({name, "_frame_end_count"}, 32'(seen_frame_end), 32'(exp_frame_end));
        check_output({name, "_rx_pending"}, 32'(exp_rx.size()), 32'd0);
        check_output({name, "_miso_pending"}, 32'(exp_miso.size()), 32'd0);
        exp_rx.delete();
        exp_miso.delete();
        exp_underrun   = 0;
        exp_frame_end  = 0;
        seen_underrun  = 0;
        seen_frame_end = 0;
    endtask

    // Receive-side and pulse monitor, sampled on the falling clk25 edge
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk25);
            if (rx_valid) begin
                if (exp_rx.size() == 0) begin
                    report_fail("rx_unexpected", 32'({rx_first, rx_data}));
                end else begin
                    e = exp_rx.pop_front();
                    check_output("rx_byte", 32'({rx_first, rx_data}), 32'(e));
                end
            end
            if (underrun)  seen_underrun++;
            if (frame_end) seen_frame_end++;
        end
    end

    // MISO monitor: assembles the bits the host samples on its SCLK rises
    initial begin
        int n;
        logic [7:0] sh;
        n  = 0;
        sh = 8'h00;
        forever begin
            @(posedge spi_sclk or posedge spi_cs_n);
            if (spi_cs_n) begin
                n = 0;
            end else if (miso_track) begin
                check_output("miso_oe", 32'(spi_miso_oe), 32'd1);
                sh = {sh[6:0], spi_miso};
                n++;
                if (n == 8) begin
                    n = 0;
                    if (exp_miso.size() == 0) report_fail("miso_unexpected", 32'(sh));
                    else check_output("miso_byte", 32'(sh), 32'(exp_miso.pop_front()));
                end
            end
        end
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        byte_arr_t mosi_b;
        byte_arr_t feed_b;
        en_arr_t   feed_en;
        int hp;

        hp       = 6;
        rst      = 1'b1;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        for (int j = 0; j < 16; j++) begin
            mosi_b[j] = 8'h00; feed_b[j] = 8'h00; feed_en[j] = 1'b0;
        end
        wait_cycles(3);
        check_output("reset_miso", 32'(spi_miso), 32'd1);
        check_output("reset_miso_oe", 32'(spi_miso_oe), 32'd0);
        check_output("reset_rx_data", 32'(rx_data), 32'd0);
        check_output("reset_rx_valid", 32'(rx_valid), 32'd0);
        check_output("reset_rx_first", 32'(rx_first), 32'd0);
        check_output("reset_tx_ready", 32'(tx_ready), 32'd1);
        check_output("reset_frame_end", 32'(frame_end), 32'd0);
        check_output("reset_underrun", 32'(underrun), 32'd0);
        rst = 1'b0;
        wait_cycles(8);

        // Single byte with a byte queued while idle
        offer_tx(8'hA5);
        mosi_b[0] = 8'h3C;
        apply_stimulus(8, mosi_b, feed_b, feed_en, hp);
        end_test("t1");

        // Three bytes, second tx byte fed mid-frame, third underruns
        offer_tx(8'h11);
        mosi_b[0] = 8'h01; mosi_b[1] = 8'h02; mosi_b[2] = 8'h03;
        feed_b[1] = 8'h22; feed_en[1] = 1'b1;
        apply_stimulus(24, mosi_b, feed_b, feed_en, hp);
        feed_en[1] = 1'b0;
        end_test("t2");

        // Nothing queued at CS fall
        mosi_b[0] = 8'($urandom);
        apply_stimulus(8, mosi_b, feed_b, feed_en, hp);
        check_output("t3_tx_ready", 32'(tx_ready), 32'(model_hold.size() == 0));
        end_test("t3");

        // Partial byte, then a byte queued mid-frame survives into the next frame
        mosi_b[0] = 8'($urandom);
        feed_b[1] = 8'h5A; feed_en[1] = 1'b1;
        apply_stimulus(5, mosi_b, feed_b, feed_en, hp);
        feed_en[1] = 1'b0;
        check_output("t4_tx_ready_held", 32'(tx_ready), 32'(model_hold.size() == 0));
        mosi_b[0] = 8'($urandom);
        apply_stimulus(8, mosi_b, feed_b, feed_en, hp);
        end_test("t4");

        // Reset during a frame with CS_N held low
        miso_track = 1'b0;
        spi_cs_n   = 1'b0;
        wait_cycles(hp);
        for (int j = 0; j < 3; j++) clock_bit(1'($urandom), hp);
        offer_tx(8'h77);
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        model_hold.delete();
        exp_underrun   = 0;
        exp_frame_end  = 0;
        seen_underrun  = 0;
        seen_frame_end = 0;
        wait_cycles(1);
        check_output("t5_tx_ready_after_rst", 32'(tx_ready), 32'(model_hold.size() == 0));
        for (int j = 0; j < 8; j++) clock_bit(1'($urandom), hp);
        wait_cycles(2 * hp);
        check_output("t5_no_rx_while_unarmed", 32'(exp_rx.size()), 32'd0);
        spi_cs_n = 1'b1;
        wait_cycles(2 * hp);
        seen_frame_end = 0;
        miso_track     = 1'b1;
        mosi_b[0]      = 8'hC3;
        apply_stimulus(8, mosi_b, feed_b, feed_en, hp);
        end_test("t5");

        // Sixteen random bytes at the fastest legal host rate
        hp = MIN_HALF_PERIOD;
        for (int j = 0; j < 16; j++) begin
            mosi_b[j]  = 8'($urandom);
            feed_b[j]  = 8'($urandom);
            feed_en[j] = (j != 0);
        end
        offer_tx(feed_b[0]);
        apply_stimulus(128, mosi_b, feed_b, feed_en, hp);
        end_test("t6");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
